elevator_display_sequencer: RTL

//  Upstream stage of the 7-seg decoder bcd_to_display. Turns live elevator status
//  (floor, direction, door) into a time-multiplexed stream of 4-bit display codes.
//  One display shows floor and status alternately, each for a fixed dwell time.
//  The BCD output connects directly to bcd_to_display.BCD.

---
 rtl/elevator_display_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/elevator_display_sequencer.sv
// Time-multiplexes elevator floor and status into 4-bit display codes for bcd_to_display.
// Optional feature macro: SEQ_FLOOR_PREFIX_EN adds a leading "piso" prefix code (9) to each sequence.
module elevator_display_sequencer #(
  parameter int DWELL_CYCLES = 100_000_000,
  parameter int CNT_W        = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] floor,
  input  logic       moving_up,
  input  logic       moving_down,
  input  logic       door_open,
  output logic [3:0] BCD,
  output logic       frame_start
);

`ifdef SEQ_FLOOR_PREFIX_EN
  typedef enum logic [1:0] {S_WAIT, S_PREFIX, S_FLOOR, S_STATUS} state_t;
  localparam state_t FIRST_STATE = S_PREFIX;
`else
  typedef enum logic [1:0] {S_WAIT, S_FLOOR, S_STATUS} state_t;
  localparam state_t FIRST_STATE = S_FLOOR;
`endif

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       floor_reg;
  logic             up_reg;
  logic             down_reg;
  logic             door_reg;
  logic [6:0]       key_reg;

  logic [3:0] cls_code;
  logic       fault;
  logic [6:0] key;
  logic [3:0] restart_code;
  logic [3:0] wrap_code;

  // Status class and fault are decoded only from the registered inputs.
  always_comb begin
    cls_code = 4'd7;
    if (up_reg && !down_reg)      cls_code = 4'd5;
    else if (down_reg && !up_reg) cls_code = 4'd8;
    else if (door_reg)            cls_code = 4'd6;
    fault = (up_reg && down_reg) || (floor_reg == 3'd0) || (floor_reg > 3'd4);
    key   = {floor_reg, cls_code};
  end

`ifdef SEQ_FLOOR_PREFIX_EN
  assign restart_code = 4'd9;
  assign wrap_code    = 4'd9;
`else
  assign restart_code = {1'b0, floor_reg};
  assign wrap_code    = {1'b0, key_reg[6:4]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_WAIT;
      cnt_reg     <= '0;
      floor_reg   <= '0;
      up_reg      <= 1'b0;
      down_reg    <= 1'b0;
      door_reg    <= 1'b0;
      key_reg     <= '0;
      BCD         <= 4'd0;
      frame_start <= 1'b0;
    end else begin
      floor_reg   <= floor;
      up_reg      <= moving_up;
      down_reg    <= moving_down;
      door_reg    <= door_open;
      frame_start <= 1'b0;
      if (fault) begin
        state_reg <= S_WAIT;
        cnt_reg   <= '0;
        BCD       <= 4'd0;
      end else if (state_reg == S_WAIT || key != key_reg) begin
        // Restart outranks any dwell expiry on the same edge.
        state_reg   <= FIRST_STATE;
        cnt_reg     <= '0;
        key_reg     <= key;
        BCD         <= restart_code;
        frame_start <= 1'b1;
      end else if (cnt_reg == DWELL_LAST) begin
        cnt_reg <= '0;
        case (state_reg)
`ifdef SEQ_FLOOR_PREFIX_EN
          S_PREFIX: begin
            state_reg <= S_FLOOR;
            BCD       <= {1'b0, key_reg[6:4]};
          end
`endif
          S_FLOOR: begin
            state_reg <= S_STATUS;
            BCD       <= key_reg[3:0];
          end
          S_STATUS: begin
            state_reg   <= FIRST_STATE;
            BCD         <= wrap_code;
            frame_start <= 1'b1;
          end
          default: begin
            state_reg <= S_WAIT;
            BCD       <= 4'd0;
          end
        endcase
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule
